// File: rtl/spi_peripheral.sv
// SPI mode-0 responder: oversamples SCLK/CS_N/MOSI with i_clk, deserialises MOSI
// and serialises MISO from a single-entry transmit holding register.
//
// state  | meaning
// IDLE   | deselected, MISO tri-stated, SCLK edges ignored
// ACTIVE | selected, shifting words on synchronised SCLK edges
module spi_peripheral #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_sclk,
  input  logic             i_cs_n,
  input  logic             i_mosi,
  output logic             o_miso,
  output logic             o_miso_oe,
  input  logic [WIDTH-1:0] i_tx_data,
  input  logic             i_tx_valid,
  output logic             o_tx_ready,
  output logic [WIDTH-1:0] o_rx_data,
  output logic             o_rx_valid,
  output logic             o_tx_underrun,
  output logic             o_busy
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  generate
    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
      $error("spi_peripheral: SYNC_STAGES must be 2 or 3");
    end
  endgenerate

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_prev, cs_prev;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-2:0] rx_shift;
  logic [WIDTH-1:0] rx_next;
  logic [WIDTH-1:0] tx_shift;
  logic [WIDTH-1:0] hold_data;
  logic             hold_full;
  logic             accept;

  logic do_start, do_clear, do_sample, do_load, do_shift;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_mosi};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign cs_rise   = cs_s & ~cs_prev;
  assign cs_fall   = ~cs_s & cs_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Deselect takes priority over any SCLK edge seen in the same cycle.
  always_comb begin
    state_d   = state_q;
    do_start  = 1'b0;
    do_clear  = 1'b0;
    do_sample = 1'b0;
    do_load   = 1'b0;
    do_shift  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d  = ACTIVE;
          do_start = 1'b1;
          do_load  = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d  = IDLE;
          do_clear = 1'b1;
        end else begin
          if (sclk_rise) do_sample = 1'b1;
          if (sclk_fall) begin
            if (bit_cnt == '0) do_load  = 1'b1;
            else               do_shift = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_next = {rx_shift, mosi_s};
  assign accept  = i_tx_valid & ~hold_full;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bit_cnt       <= '0;
      rx_shift      <= '0;
      o_rx_data     <= '0;
      o_rx_valid    <= 1'b0;
      tx_shift      <= '0;
      o_tx_underrun <= 1'b0;
    end else begin
      o_rx_valid    <= 1'b0;
      o_tx_underrun <= 1'b0;

      if (do_start || do_clear) begin
        bit_cnt  <= '0;
        rx_shift <= '0;
      end else if (do_sample) begin
        rx_shift <= rx_next[WIDTH-2:0];
        if (bit_cnt == CNT_W'(WIDTH - 1)) begin
          bit_cnt    <= '0;
          o_rx_data  <= rx_next;
          o_rx_valid <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end

      // An empty holding register at word start sends zeros and flags it.
      if (do_clear) begin
        tx_shift <= '0;
      end else if (do_load) begin
        tx_shift      <= hold_full ? hold_data : '0;
        o_tx_underrun <= ~hold_full;
      end else if (do_shift) begin
        tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hold_data <= '0;
      hold_full <= 1'b0;
    end else if (accept) begin
      hold_data <= i_tx_data;
      hold_full <= 1'b1;
    end else if (do_load && hold_full) begin
      hold_full <= 1'b0;
    end
  end

  assign o_tx_ready = ~hold_full;
  assign o_miso     = tx_shift[WIDTH-1];
  assign o_miso_oe  = (state_q == ACTIVE);
  assign o_busy     = (state_q == ACTIVE);

endmodule

// File: tb/tb_spi_peripheral.sv
// Self-checking bench for spi_peripheral: bit-banged mode-0 controller, queue-based
// TX feeder and RX monitor, compared against expected word streams.
module tb_spi_peripheral;

  localparam int W = 8;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_sclk;
  logic         i_cs_n;
  logic         i_mosi;
  logic         o_miso;
  logic         o_miso_oe;
  logic [W-1:0] i_tx_data;
  logic         i_tx_valid;
  logic         o_tx_ready;
  logic [W-1:0] o_rx_data;
  logic         o_rx_valid;
  logic         o_tx_underrun;
  logic         o_busy;

  spi_peripheral #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_sclk(i_sclk), .i_cs_n(i_cs_n), .i_mosi(i_mosi),
    .o_miso(o_miso), .o_miso_oe(o_miso_oe), .i_tx_data(i_tx_data), .i_tx_valid(i_tx_valid),
    .o_tx_ready(o_tx_ready), .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid),
    .o_tx_underrun(o_tx_underrun), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;
  int underrun_cnt = 0;

  logic [W-1:0] tx_q[$];
  logic [W-1:0] mosi_q[$];
  logic [W-1:0] miso_got[$];
  logic [W-1:0] rx_got[$];
  logic [W-1:0] exp_miso[$];
  logic         ready_pre = 1'b0;

  // TX feeder: keeps the holding register topped up from tx_q.
  initial begin
    i_tx_valid = 1'b0;
    i_tx_data  = '0;
    forever begin
      @(posedge i_clk);
      if (i_tx_valid && ready_pre && !i_rst) void'(tx_q.pop_front());
      #1;
      if (tx_q.size() > 0) begin
        i_tx_valid = 1'b1;
        i_tx_data  = tx_q[0];
      end else begin
        i_tx_valid = 1'b0;
      end
      ready_pre = o_tx_ready;
    end
  end

  initial begin
    forever begin
      @(negedge i_clk);
      if (o_rx_valid === 1'b1) rx_got.push_back(o_rx_data);
      if (o_tx_underrun === 1'b1) underrun_cnt++;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge i_clk);
    #2;
  endtask

  // Full-word mode-0 transfer of every word in mosi_q; last SCLK fall coincides with deselect.
  task automatic xfer(input int half);
    logic [W-1:0] w;
    logic [W-1:0] m;
    miso_got.delete();
    i_cs_n = 1'b0;
    for (int k = 0; k < mosi_q.size(); k++) begin
      w = mosi_q[k];
      m = '0;
      for (int i = W - 1; i >= 0; i--) begin
        i_mosi = w[i];
        wait_clk(half);
        m[i] = o_miso;
        if (i == W - 1) begin
          n_cmp++;
          if (o_miso_oe !== 1'b1 || o_busy !== 1'b1) begin
            n_err++;
            $display("FAIL xfer_active word %0d: oe=%b busy=%b, required 1/1", k, o_miso_oe, o_busy);
          end
        end
        i_sclk = 1'b1;
        wait_clk(half);
        i_sclk = 1'b0;
        if (k == mosi_q.size() - 1 && i == 0) i_cs_n = 1'b1;
      end
      miso_got.push_back(m);
    end
    i_mosi = 1'b0;
    wait_clk(half + 6);
  endtask

  task automatic test_reset_values;
    i_rst = 1'b1; i_sclk = 1'b0; i_cs_n = 1'b1; i_mosi = 1'b0;
    wait_clk(3);
    n_cmp++;
    if ({o_miso, o_miso_oe, o_rx_valid, o_tx_underrun, o_busy, o_tx_ready} !== 6'b000001 || o_rx_data !== '0) begin
      n_err++;
      $display("FAIL reset_values: miso/oe/rxv/unr/busy/rdy=%b%b%b%b%b%b rx=%h, required 000001 rx=00",
               o_miso, o_miso_oe, o_rx_valid, o_tx_underrun, o_busy, o_tx_ready, o_rx_data);
    end
    i_rst = 1'b0;
    wait_clk(3);
  endtask

  task automatic test_single;
    tx_q = '{8'hA5};
    mosi_q = '{8'h5A};
    wait_clk(5);
    n_cmp++;
    if (o_tx_ready !== 1'b0) begin n_err++; $display("FAIL single_preload_ready: got %b required 0", o_tx_ready); end
    rx_got.delete(); underrun_cnt = 0;
    xfer(50);
    n_cmp++;
    if (miso_got[0] !== 8'hA5) begin n_err++; $display("FAIL single_miso: got %h required a5", miso_got[0]); end
    n_cmp++;
    if (rx_got.size() != 1) begin n_err++; $display("FAIL single_rx_count: got %0d required 1", rx_got.size()); end
    else begin
      n_cmp++;
      if (rx_got[0] !== 8'h5A) begin n_err++; $display("FAIL single_rx: got %h required 5a", rx_got[0]); end
    end
    n_cmp++;
    if (o_rx_data !== 8'h5A) begin n_err++; $display("FAIL single_rx_hold: got %h required 5a", o_rx_data); end
    n_cmp++;
    if (underrun_cnt != 0) begin n_err++; $display("FAIL single_underrun: got %0d required 0", underrun_cnt); end
    n_cmp++;
    if ({o_tx_ready, o_miso_oe, o_busy, o_miso} !== 4'b1000) begin
      n_err++;
      $display("FAIL single_idle: rdy/oe/busy/miso=%b%b%b%b required 1000", o_tx_ready, o_miso_oe, o_busy, o_miso);
    end
  endtask

  task automatic test_reset_mid;
    tx_q = '{8'hE1, 8'hE2};
    wait_clk(5);
    i_cs_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_mosi = $urandom_range(0, 1);
      wait_clk(10);
      i_sclk = 1'b1;
      wait_clk(10);
      i_sclk = 1'b0;
    end
    wait_clk(4);
    n_cmp++;
    if (o_busy !== 1'b1 || o_tx_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_pre: busy=%b rdy=%b required 1/0", o_busy, o_tx_ready);
    end
    i_rst = 1'b1;
    #1;
    n_cmp++;
    if ({o_miso, o_miso_oe, o_rx_valid, o_tx_underrun, o_busy, o_tx_ready} !== 6'b000001 || o_rx_data !== '0) begin
      n_err++;
      $display("FAIL reset_async: miso/oe/rxv/unr/busy/rdy=%b%b%b%b%b%b rx=%h, required 000001 rx=00",
               o_miso, o_miso_oe, o_rx_valid, o_tx_underrun, o_busy, o_tx_ready, o_rx_data);
    end
    i_cs_n = 1'b1; i_sclk = 1'b0; i_mosi = 1'b0;
    wait_clk(3);
    i_rst = 1'b0;
    wait_clk(3);
    tx_q = '{8'h4B};
    mosi_q = '{8'h3C};
    wait_clk(5);
    rx_got.delete();
    xfer(10);
    n_cmp++;
    if (rx_got.size() != 1 || rx_got[0] !== 8'h3C) begin
      n_err++;
      $display("FAIL reset_after_rx: count %0d first %h, required 1 word 3c", rx_got.size(), rx_got.size() ? rx_got[0] : 8'h00);
    end
    n_cmp++;
    if (miso_got[0] !== 8'h4B) begin n_err++; $display("FAIL reset_after_miso: got %h required 4b", miso_got[0]); end
  endtask

  task automatic test_back_to_back;
    exp_miso = '{8'h11, 8'h22, 8'h33};
    tx_q = exp_miso;
    mosi_q = '{8'h01, 8'h80, 8'hFF};
    wait_clk(5);
    rx_got.delete(); underrun_cnt = 0;
    xfer(10);
    n_cmp++;
    if (rx_got.size() != 3) begin n_err++; $display("FAIL b2b_rx_count: got %0d required 3", rx_got.size()); end
    for (int k = 0; k < 3; k++) begin
      if (k < rx_got.size()) begin
        n_cmp++;
        if (rx_got[k] !== mosi_q[k]) begin n_err++; $display("FAIL b2b_rx[%0d]: got %h required %h", k, rx_got[k], mosi_q[k]); end
      end
      n_cmp++;
      if (miso_got[k] !== exp_miso[k]) begin n_err++; $display("FAIL b2b_miso[%0d]: got %h required %h", k, miso_got[k], exp_miso[k]); end
    end
    n_cmp++;
    if (underrun_cnt != 0) begin n_err++; $display("FAIL b2b_underrun: got %0d required 0", underrun_cnt); end
  endtask

  task automatic test_underrun;
    logic [W-1:0] w;
    w = W'($urandom);
    tx_q.delete();
    mosi_q = '{w};
    wait_clk(5);
    rx_got.delete(); underrun_cnt = 0;
    xfer(10);
    n_cmp++;
    if (underrun_cnt != 1) begin n_err++; $display("FAIL underrun_count: got %0d required 1", underrun_cnt); end
    n_cmp++;
    if (miso_got[0] !== 8'h00) begin n_err++; $display("FAIL underrun_miso: got %h required 00", miso_got[0]); end
    n_cmp++;
    if (rx_got.size() != 1 || rx_got[0] !== w) begin
      n_err++;
      $display("FAIL underrun_rx: count %0d first %h, required 1 word %h", rx_got.size(), rx_got.size() ? rx_got[0] : 8'h00, w);
    end
  endtask

  task automatic test_abort;
    tx_q = '{8'h77, 8'h96};
    wait_clk(5);
    rx_got.delete(); underrun_cnt = 0;
    i_cs_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      i_mosi = $urandom_range(0, 1);
      wait_clk(10);
      i_sclk = 1'b1;
      wait_clk(10);
      i_sclk = 1'b0;
    end
    wait_clk(10);
    i_cs_n = 1'b1;
    wait_clk(10);
    n_cmp++;
    if (rx_got.size() != 0) begin n_err++; $display("FAIL abort_rx_valid: got %0d pulses required 0", rx_got.size()); end
    n_cmp++;
    if ({o_miso_oe, o_busy, o_miso} !== 3'b000) begin
      n_err++;
      $display("FAIL abort_idle: oe/busy/miso=%b%b%b required 000", o_miso_oe, o_busy, o_miso);
    end
    n_cmp++;
    if (o_tx_ready !== 1'b0) begin n_err++; $display("FAIL abort_hold_kept: ready %b required 0", o_tx_ready); end
    mosi_q = '{8'hC3};
    xfer(10);
    n_cmp++;
    if (rx_got.size() != 1 || rx_got[0] !== 8'hC3) begin
      n_err++;
      $display("FAIL abort_next_rx: count %0d first %h, required 1 word c3", rx_got.size(), rx_got.size() ? rx_got[0] : 8'h00);
    end
    n_cmp++;
    if (miso_got[0] !== 8'h96) begin n_err++; $display("FAIL abort_next_miso: got %h required 96", miso_got[0]); end
    n_cmp++;
    if (underrun_cnt != 0) begin n_err++; $display("FAIL abort_underrun: got %0d required 0", underrun_cnt); end
  endtask

  task automatic test_max_rate;
    int bad_rx;
    int bad_tx;
    exp_miso.delete();
    mosi_q.delete();
    for (int k = 0; k < 64; k++) begin
      exp_miso.push_back(W'($urandom));
      mosi_q.push_back(W'($urandom));
    end
    tx_q = exp_miso;
    wait_clk(5);
    rx_got.delete(); underrun_cnt = 0;
    xfer(4);
    n_cmp++;
    if (rx_got.size() != 64) begin n_err++; $display("FAIL max_rx_count: got %0d required 64", rx_got.size()); end
    bad_rx = 0;
    bad_tx = 0;
    for (int k = 0; k < 64; k++) begin
      if (k < rx_got.size()) begin
        n_cmp++;
        if (rx_got[k] !== mosi_q[k]) begin
          n_err++; bad_rx++;
          if (bad_rx <= 4) $display("FAIL max_rx[%0d]: got %h required %h", k, rx_got[k], mosi_q[k]);
        end
      end
      n_cmp++;
      if (miso_got[k] !== exp_miso[k]) begin
        n_err++; bad_tx++;
        if (bad_tx <= 4) $display("FAIL max_miso[%0d]: got %h required %h", k, miso_got[k], exp_miso[k]);
      end
    end
    n_cmp++;
    if (underrun_cnt != 0) begin n_err++; $display("FAIL max_underrun: got %0d required 0", underrun_cnt); end
  endtask

  initial begin
    test_reset_values();
    test_single();
    test_reset_mid();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_max_rate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_peripheral.md
Name: spi_peripheral

Overview:
SPI responder (mode 0: CPOL=0, CPHA=0, MSB first). It is the far end of the link driven by our SPI controller and clock_divider, used for loopback and system-level verification of the controller. It oversamples the externally supplied i_sclk, i_cs_n and i_mosi with the local i_clk, deserialises MOSI words and serialises MISO words. MISO words come from a single-entry transmit holding register.

Parameters:
WIDTH, 8, bits per SPI word
SYNC_STAGES, 2, flip-flop stages in each input synchroniser (legal range 2..3)

Ports:
i_clk  input  1  system clock; must be ≥ 8× the SCLK frequency
i_rst  input  1  asynchronous, active-high reset
i_sclk  input  1  SPI serial clock from controller, asynchronous to i_clk
i_cs_n  input  1  active-low chip select, asynchronous
i_mosi  input  1  serial data from controller, asynchronous
o_miso  output  1  serial data to controller
o_miso_oe  output  1  MISO output enable; 1 only while selected
i_tx_data  input  WIDTH  next word to transmit
i_tx_valid  input  1  i_tx_data valid
o_tx_ready  output  1  holding register empty; transfer occurs when i_tx_valid & o_tx_ready
o_rx_data  output  WIDTH  last fully received word; held until the next one completes
o_rx_valid  output  1  one-cycle pulse when o_rx_data updates
o_tx_underrun  output  1  one-cycle pulse when a word is loaded for shifting while the holding register is empty
o_busy  output  1  high in ACTIVE state

Behaviour:
- Reset (i_rst=1, takes effect immediately): state IDLE; synchronisers reset to sclk=0, cs_n=1, mosi=0. o_miso=0, o_miso_oe=0, o_rx_data=0, o_rx_valid=0, o_tx_underrun=0, o_busy=0, o_tx_ready=1. Holding register and shift registers are cleared.
- All three SPI inputs pass through SYNC_STAGES flops. Edges are detected by comparing the synchronised value with its registered previous value. All logic uses only the synchronised signals.
- Holding register: accepts i_tx_data when i_tx_valid & o_tx_ready, then o_tx_ready=0 on the next cycle. The register empties (o_tx_ready=1 next cycle) when its word is loaded into the TX shifter. Accept and consume never coincide, because ready is low while the register is full.
- "Word load": the TX shifter takes the holding register if it is full. If it is empty, the shifter takes all-zeros and o_tx_underrun pulses.
- State IDLE -> ACTIVE on the synchronised cs_n falling edge. In the same cycle: bit_cnt=0, word load, o_miso_oe=1, o_miso = shifter MSB. This satisfies CPHA=0, where the first bit is valid before the first SCLK rise.
- In ACTIVE, on a synchronised sclk rise: shift the synchronised MOSI into the RX shifter LSB and increment bit_cnt. When bit_cnt was WIDTH-1, register the completed word into o_rx_data, pulse o_rx_valid on the same edge, and wrap bit_cnt to 0. Latency from the final i_sclk rise to o_rx_valid is SYNC_STAGES+1 i_clk edges.
- In ACTIVE, on a synchronised sclk fall: if bit_cnt==0 (word boundary), do a word load to support back-to-back words; otherwise shift the TX shifter left. o_miso always equals the shifter MSB, so it updates SYNC_STAGES+1 edges after the i_sclk fall, which fits within the half-period at 8× oversampling.
- ACTIVE -> IDLE on the synchronised cs_n rising edge, including mid-word:
  - partial RX bits are discarded, with no o_rx_valid;
  - the partial TX word is dropped;
  - bit_cnt=0, o_miso_oe=0, o_miso=0;
  - the holding register keeps any unconsumed word.
- sclk edges while IDLE are ignored. A sclk edge coinciding with the cs_n rise is ignored, because deselect wins. A cs_n fall coinciding with a sclk edge performs only the select actions.
- The RX side has no backpressure. A new o_rx_valid simply overwrites o_rx_data.

Test Plan:
- Reset: assert i_rst mid-transfer (after 3 bits) -> outputs immediately at reset values, o_tx_ready=1. After release, a full 0x3C transfer is received correctly.
- Single word, i_clk=100 MHz, SCLK=1 MHz: preload tx 0xA5, controller sends 0x5A -> MISO sampled as 0xA5, o_rx_data=0x5A with exactly one o_rx_valid pulse, o_tx_underrun never pulses, o_tx_ready=1 after CS fall.
- Back-to-back: CS held low for 3 words, MOSI 0x01,0x80,0xFF; tx refilled with 0x11,0x22,0x33 whenever ready -> MISO 0x11,0x22,0x33, three o_rx_valid pulses in order, no underrun.
- Underrun: no tx word loaded, CS falls -> o_tx_underrun pulses once, MISO reads 0x00, and RX still completes.
- Abort: CS rises after 5 SCLK rises -> no o_rx_valid, o_miso_oe=0, o_busy=0. The next full transfer of 0xC3 is received as 0xC3, confirming bit_cnt was cleared.
- Max rate: SCLK = i_clk/8 with random 64-word stream on both sides -> every RX word and MISO word matches the scoreboard.
